// File: rtl/ql_int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ql_int_pkg
// Description : Shared types and constants for the ql_int_ctrl interrupt
//               controller (FSM states, config addresses, STATUS layout).
// Revision    : 1.0 - initial release
// ============================================================================
package ql_int_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACTIVE   = 2'd2,
        REQ_NEST = 2'd3
    } state_t;

    localparam logic [1:0] c_ADDR_MASK   = 2'd0;
    localparam logic [1:0] c_ADDR_EDGE   = 2'd1;
    localparam logic [1:0] c_ADDR_PEND   = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    localparam int c_IDX_W = 5;
    localparam int c_DEP_W = 3;

    localparam int c_STAT_ACT_LSB   = 0;
    localparam int c_STAT_STATE_LSB = 8;
    localparam int c_STAT_DEPTH_LSB = 10;

endpackage
`default_nettype wire

// File: rtl/ql_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ql_int_ctrl_if
// Description : Config bus and request/ack/done handshake between the
//               interrupt controller (slave) and the core (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface ql_int_ctrl_if #(
    parameter int NUM_W = 8
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             int_ask;
    logic [NUM_W-1:0] int_num;
    logic             int_ack;
    logic             int_done;
    logic             int_active;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        input  cfg_rdata, int_ask, int_num, int_active
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
        output cfg_rdata, int_ask, int_num, int_active
    );
endinterface
`default_nettype wire

// File: rtl/ql_int_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : ql_int_prio_enc
// Description : Lowest-index-wins priority encoder over CH_NUM request bits.
// Revision    : 1.0 - initial release
// ============================================================================
module ql_int_prio_enc
    import ql_int_pkg::*;
#(
    parameter int CH_NUM = 8
) (
    input  wire logic [CH_NUM-1:0]  i_req,
    output logic      [c_IDX_W-1:0] o_idx,
    output logic                    o_vld
);

    // Scanning downward leaves the lowest set index as the final assignment.
    always_comb begin
        o_idx = '0;
        o_vld = |i_req;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = c_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ql_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ql_int_ctrl
// Description : CH_NUM-source maskable interrupt controller with edge/level
//               pending, fixed priority and a vectored request handshake.
//               Define QL_INT_NEST_EN for nested preemption (NEST_DEPTH).
// Revision    : 1.0 - initial release
// ============================================================================
module ql_int_ctrl
    import ql_int_pkg::*;
#(
    parameter int CH_NUM     = 8,
    parameter int NUM_W      = 8,
    parameter int BASE_NUM   = 32,
    parameter int NEST_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [CH_NUM-1:0] irq_in,
    input  wire logic              sys_int_en,
    ql_int_ctrl_if.slave           bus
);

`ifdef QL_INT_NEST_EN
    localparam int c_STACK_DEPTH = NEST_DEPTH;
`else
    // Single active level: the stack collapses to one entry.
    localparam int c_STACK_DEPTH = (NEST_DEPTH > 1) ? 1 : NEST_DEPTH;
`endif

    state_t              r_state;
    logic [CH_NUM-1:0]   r_mask;
    logic [CH_NUM-1:0]   r_edge;
    logic [CH_NUM-1:0]   r_pend;
    logic [CH_NUM-1:0]   r_irq_prev;
    logic                r_ask;
    logic [NUM_W-1:0]    r_num;
    logic                r_active;
    logic [c_IDX_W-1:0]  r_win_idx;
    logic [c_DEP_W-1:0]  r_depth;
    logic [c_IDX_W-1:0]  r_stack     [c_STACK_DEPTH];
    logic [c_IDX_W-1:0]  w_stack_nxt [c_STACK_DEPTH];

    logic [CH_NUM-1:0]   w_rise;
    logic [CH_NUM-1:0]   w_clr;
    logic [CH_NUM-1:0]   w_pend_nxt;
    logic [CH_NUM-1:0]   w_elig;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic                w_win_vld;
    logic [NUM_W-1:0]    w_vec;
    logic                w_push;
    logic                w_pop;
    logic                w_preempt;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    assign w_push = bus.int_ack  && ((r_state == REQ) || (r_state == REQ_NEST));
    assign w_pop  = bus.int_done && (r_state == ACTIVE);

    // Edge channels: a new edge beats any clear landing in the same cycle.
    assign w_rise = irq_in & ~r_irq_prev;
    assign w_clr  = ((bus.cfg_we && (bus.cfg_addr == c_ADDR_PEND)) ? bus.cfg_wdata[CH_NUM-1:0] : '0)
                  | (w_push ? (CH_NUM'(1) << r_win_idx) : '0);
    assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & irq_in);

    assign w_elig = r_pend & r_mask;
    assign w_vec  = NUM_W'(BASE_NUM) + NUM_W'(w_win_idx);

    ql_int_prio_enc #(
        .CH_NUM (CH_NUM)
    ) u_prio_enc (
        .i_req  (w_elig),
        .o_idx  (w_win_idx),
        .o_vld  (w_win_vld)
    );

`ifdef QL_INT_NEST_EN
    assign w_preempt = sys_int_en && w_win_vld && (w_win_idx < r_stack[0])
                    && (r_depth < c_DEP_W'(c_STACK_DEPTH));
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_edge     <= '0;
            r_pend     <= '0;
            r_irq_prev <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pend     <= w_pend_nxt;
            if (bus.cfg_we && (bus.cfg_addr == c_ADDR_MASK)) begin
                r_mask <= bus.cfg_wdata[CH_NUM-1:0];
            end
            if (bus.cfg_we && (bus.cfg_addr == c_ADDR_EDGE)) begin
                r_edge <= bus.cfg_wdata[CH_NUM-1:0];
            end
        end
    end

    // Once raised, a request is held until ack regardless of source or mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ask     <= 1'b0;
            r_num     <= '0;
            r_active  <= 1'b0;
            r_win_idx <= '0;
            r_depth   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sys_int_en && w_win_vld) begin
                        r_win_idx <= w_win_idx;
                        r_ask     <= 1'b1;
                        r_num     <= w_vec;
                        r_state   <= REQ;
                    end
                end
                REQ, REQ_NEST: begin
                    if (bus.int_ack) begin
                        r_ask    <= 1'b0;
                        r_active <= 1'b1;
                        r_depth  <= r_depth + c_DEP_W'(1);
                        r_state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.int_done) begin
                        r_depth <= r_depth - c_DEP_W'(1);
                        if (r_depth == c_DEP_W'(1)) begin
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end else if (w_preempt) begin
                        r_win_idx <= w_win_idx;
                        r_ask     <= 1'b1;
                        r_num     <= w_vec;
                        r_state   <= REQ_NEST;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Entry 0 is top of stack; push shifts toward older entries.
    genvar gi;
    generate
        for (gi = 0; gi < c_STACK_DEPTH; gi++) begin : g_stack
            logic [c_IDX_W-1:0] w_newer;
            logic [c_IDX_W-1:0] w_older;
            if (gi == 0) begin : g_top
                assign w_newer = r_win_idx;
            end else begin : g_inner
                assign w_newer = r_stack[gi-1];
            end
            if (gi == c_STACK_DEPTH - 1) begin : g_last
                assign w_older = '0;
            end else begin : g_link
                assign w_older = r_stack[gi+1];
            end
            assign w_stack_nxt[gi] = w_push ? w_newer : (w_pop ? w_older : r_stack[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_stack <= w_stack_nxt;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[c_STAT_ACT_LSB   +: c_IDX_W] = r_stack[0];
        w_status[c_STAT_STATE_LSB +: 2]       = r_state;
        w_status[c_STAT_DEPTH_LSB +: c_DEP_W] = r_depth;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.cfg_addr)
            c_ADDR_MASK:   w_rdata = 32'(r_mask);
            c_ADDR_EDGE:   w_rdata = 32'(r_edge);
            c_ADDR_PEND:   w_rdata = 32'(r_pend);
            c_ADDR_STATUS: w_rdata = w_status;
            default:       w_rdata = '0;
        endcase
    end

    assign w_unused_wdata = &{1'b0, bus.cfg_wdata};

    assign bus.cfg_rdata  = w_rdata;
    assign bus.int_ask    = r_ask;
    assign bus.int_num    = r_num;
    assign bus.int_active = r_active;

endmodule
`default_nettype wire

// File: doc/ql_int_ctrl.md
Name: ql_int_ctrl

Overview:
Parametrised multi-channel interrupt controller for the 023A-class cores. It replaces the single external int_ask/int_num pair with CH_NUM independently maskable sources. Each source has selectable edge or level mode, fixed priority, and a pending register. Output is one vectored request toward the core's interrupt unit, with a request/acknowledge/done handshake and optional nested preemption.

Parameters:
CH_NUM, 8, number of interrupt sources (1..32)
NUM_W, 8, width of the interrupt number to the core
BASE_NUM, 32, interrupt number issued for channel 0; channel i issues BASE_NUM+i
NEST_DEPTH, 4, active-channel stack depth (used only with QL_INT_NEST_EN)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
irq_in  in  CH_NUM  source lines, already synchronous to clk
sys_int_en  in  1  global enable from the sys register interrupt bit
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=MASK, 1=EDGE, 2=PENDING, 3=STATUS
cfg_wdata  in  32  write data; bits [CH_NUM-1:0] are used
cfg_rdata  out  32  combinational read of the register selected by cfg_addr
int_ask  out  1  interrupt request to the core
int_num  out  NUM_W  vector number; valid while int_ask=1
int_ack  in  1  one-cycle pulse: the core has accepted the request
int_done  in  1  one-cycle pulse: return-from-interrupt (int_clear_sign)
int_active  out  1  at least one interrupt is in service

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous, active-low.
- Reset values:
  - MASK, EDGE, PENDING, irq_prev all 0.
  - State IDLE; int_ask=0, int_num=0, int_active=0.
  - Stack empty.
  - Reset takes priority over any handshake in flight.
- Pending update, per channel i, every cycle:
  - EDGE[i]=1: set on irq_in[i] & ~irq_prev[i]. Cleared by a cfg write-1 to PENDING, or by int_ack when i is the latched winner. Set wins over clear in the same cycle.
  - EDGE[i]=0: PENDING[i] <= irq_in[i]. Write-1-clear has no lasting effect.
- Eligible set = PENDING & MASK. Winner = lowest set index.
- State machine:
  - IDLE -> REQ when sys_int_en=1 and the eligible set is non-zero.
    - In that same edge: latch win_idx, set int_ask=1, int_num=BASE_NUM+win_idx.
    - Request latency: 1 cycle after the pending bit is registered.
  - REQ: int_ask and int_num are held stable until int_ack.
    - The request is never withdrawn, even if the source drops, is masked, or sys_int_en falls. This avoids racing the core's pipeline drain.
  - REQ -> ACTIVE on int_ack.
    - int_ask=0 in the next cycle.
    - Edge-mode pending bit of win_idx is cleared.
    - win_idx becomes the active channel; int_active=1.
  - ACTIVE -> IDLE on int_done. int_active=0.
    - A new request can be raised no earlier than the cycle after the return to IDLE.
- Ignored inputs:
  - int_ack outside REQ is ignored.
  - int_done outside ACTIVE is ignored.
  - int_ack and int_done in the same cycle resolve by the current state only.
- Config:
  - Writes take effect on the next edge.
  - STATUS is read-only: [4:0] active channel, [9:8] state, [12:10] stack depth.
  - Unused high bits read 0.
  - A MASK change during REQ does not cancel the request.

Optional Feature:
QL_INT_NEST_EN
- Defined:
  - In ACTIVE, an eligible channel with index lower than the top-of-stack raises int_ask as in IDLE (state REQ_NEST). This is permitted only while stack depth < NEST_DEPTH.
  - int_ack pushes the new channel onto the stack.
  - int_done pops the stack; the state returns to IDLE only when the stack becomes empty.
  - With a full stack, preemption is blocked.
- Undefined:
  - Single active level only; NEST_DEPTH is ignored.
  - STATUS[12:10] reads 0 or 1.

Decomposition:
- Package ql_int_pkg:
  - state enum (IDLE, REQ, ACTIVE, REQ_NEST)
  - cfg address constants
  - STATUS field positions
- Sub-module ql_int_prio_enc: parametrised lowest-index priority encoder, CH_NUM inputs, index out plus valid.

Test Plan:
- Reset mid-REQ: rst_n=0 for one edge while int_ask=1 -> next cycle int_ask=0, MASK=0, STATUS=0.
- Priority: MASK=0xFF, EDGE=0xFF, rising edges on ch5 and ch2 in the same cycle -> int_num=34. After ack and done -> int_num=37.
- Held request: level ch3 requested, then irq_in[3] drops before ack -> int_num stays 35 until int_ack.
- Edge clear versus set: W1C on PENDING bit 1 in the same cycle as a new ch1 edge -> PENDING[1] remains 1.
- Global gate: sys_int_en=0 with eligible ch0 -> int_ask stays 0. Raising sys_int_en -> int_ask=1 one cycle later, int_num=32.
- Nesting (QL_INT_NEST_EN, NEST_DEPTH=2):
  - ch4 active, ch1 edge -> int_num=33 accepted, depth=2.
  - ch0 edge -> no request until one int_done.
  - Two int_done pulses -> int_active=0.
